// File: rtl/accel_pkg.sv
// Shared types and constants for the neuron MAC accelerator: FSM states, Q8.8 formats,
// header layout and the shift/saturate/ReLU result function.
package accel_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_CNT = 3'd1,
    MAC     = 3'd2,
    DRAIN   = 3'd3,
    FINISH  = 3'd4,
    DONE    = 3'd5
  } state_e;

  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 8;
  localparam int ACC_W     = 40;

  localparam logic signed [ACC_W-1:0] SAT_MAX = 40'sd32767;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -40'sd32768;

  localparam int HDR_N_LSB    = 0;
  localparam int HDR_N_MSB    = 5;
  localparam int HDR_RELU_BIT = 15;

  localparam int MAX_N_DEF      = 32;
  localparam int FIFO_DEPTH_DEF = 4;

  // Q16.16 accumulator back to Q8.8, clipped to 16 bits, optional ReLU on the clipped value.
  function automatic logic [DATA_W-1:0] sat_relu(input logic signed [ACC_W-1:0] acc,
                                                 input logic                     relu);
    logic signed [ACC_W-1:0] shifted;
    logic [DATA_W-1:0]       r;
    shifted = acc >>> FRAC_BITS;
    if (shifted > SAT_MAX) begin
      r = SAT_MAX[DATA_W-1:0];
    end else if (shifted < SAT_MIN) begin
      r = SAT_MIN[DATA_W-1:0];
    end else begin
      r = shifted[DATA_W-1:0];
    end
    if (relu && r[DATA_W-1]) begin
      r = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/operand_fifo.sv
// Operand FIFO: one-word push, pair pop of the two oldest words, head and next visible combinationally.
// Pushes while full are refused here; the caller owns the error reporting. flush empties it in one cycle.
module operand_fifo #(
  parameter int  WIDTH = 17,
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop2,
  output logic [WIDTH-1:0] head_dat,
  output logic [WIDTH-1:0] next_dat,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int unsigned step);
    int unsigned s;
    s = 32'(p) + step;
    if (s >= DEPTH) s = s - DEPTH;
    return s[PTR_W-1:0];
  endfunction

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign head_dat = mem_q[rd_ptr_q];
  assign next_dat = mem_q[ptr_add(rd_ptr_q, 1)];
  assign push_ok  = push && !full && !flush;
  assign pop_ok   = pop2 && (count_q >= CNT_W'(2)) && !flush;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = ptr_add(wr_ptr_q, 1);
      end
      if (pop_ok) begin
        rd_ptr_d = ptr_add(rd_ptr_q, 2);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(2);
        2'b11:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/neuron_mac_accel.sv
// Neuron MAC accelerator: header, then N (x,w) Q8.8 pairs; result 5 cycles after the last w.
// No backpressure: stray or overflowing writes are dropped and flagged on err; accel_en low aborts.
module neuron_mac_accel
  import accel_pkg::*;
#(
  parameter int MAX_N      = MAX_N_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              accel_en,
  input  logic              bus_wr,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic              accel_done,
  output logic [DATA_W-1:0] bus_rdata,
  output logic              busy,
  output logic              err
);

  localparam int             CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int             N_W     = HDR_N_MSB - HDR_N_LSB + 1;
  localparam int             OP_W    = DATA_W + 1;
  localparam logic [N_W-1:0] MAX_N_V = N_W'(MAX_N);

  state_e                  state_q, state_d;
  logic [N_W-1:0]          n_q, n_d;
  logic [N_W-1:0]          pair_cnt_q, pair_cnt_d;
  logic                    phase_q, phase_d;
  logic                    relu_q, relu_d;
  logic                    prod_vld_q, prod_vld_d;
  logic signed [2*DATA_W-1:0] prod_q, prod_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic            active, abort, hdr_acc, mac_wr, push, pop, last_push, bad_wr, hdr_clamp;
  logic [N_W-1:0]  hdr_n;
  logic [OP_W-1:0] fifo_head, fifo_next;
  logic            fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  assign hdr_n     = bus_wdata[HDR_N_MSB:HDR_N_LSB];
  assign hdr_clamp = (hdr_n > MAX_N_V);

  // Tag bit set on x words so the pop side can check pair alignment.
  operand_fifo #(.WIDTH(OP_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (abort),
    .push     (push),
    .push_dat ({~phase_q, bus_wdata}),
    .pop2     (pop),
    .head_dat (fifo_head),
    .next_dat (fifo_next),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accel_en) state_d = GET_CNT;
      GET_CNT: begin
        if (!accel_en)   state_d = IDLE;
        else if (bus_wr) state_d = (hdr_n == '0) ? FINISH : MAC;
      end
      MAC: begin
        if (abort)          state_d = IDLE;
        else if (last_push) state_d = DRAIN;
      end
      DRAIN: begin
        if (abort)                           state_d = IDLE;
        else if (fifo_empty && !prod_vld_q)  state_d = FINISH;
      end
      FINISH:  state_d = abort ? IDLE : DONE;
      DONE:    if (!accel_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    active    = (state_q == GET_CNT) || (state_q == MAC) || (state_q == DRAIN) || (state_q == FINISH);
    abort     = active && !accel_en;
    busy      = (state_q != IDLE) && (state_q != DONE);
    hdr_acc   = (state_q == GET_CNT) && accel_en && bus_wr;
    mac_wr    = (state_q == MAC) && accel_en && bus_wr;
    push      = mac_wr && !fifo_full;
    pop       = accel_en && ((state_q == MAC) || (state_q == DRAIN)) &&
                (fifo_count >= CNT_W'(2)) && fifo_head[DATA_W] && !fifo_next[DATA_W];
    last_push = push && phase_q && ((pair_cnt_q + N_W'(1)) == n_q);
    bad_wr    = (bus_wr && ((state_q == DRAIN) || (state_q == FINISH) || (state_q == DONE))) ||
                (mac_wr && fifo_full);
  end

  always_comb begin
    n_d        = n_q;
    pair_cnt_d = pair_cnt_q;
    phase_d    = phase_q;
    relu_d     = relu_q;
    acc_d      = acc_q;
    rdata_d    = rdata_q;
    err_d      = err_q || bad_wr;
    done_d     = 1'b0;
    prod_vld_d = pop;
    prod_d     = prod_q;

    if (pop) begin
      prod_d = (2*DATA_W)'($signed(fifo_head[DATA_W-1:0])) *
               (2*DATA_W)'($signed(fifo_next[DATA_W-1:0]));
    end
    if (prod_vld_q && !abort) begin
      acc_d = acc_q + ACC_W'(prod_q);
    end
    if (push) begin
      phase_d = ~phase_q;
      if (phase_q) pair_cnt_d = pair_cnt_q + N_W'(1);
    end
    if (state_q == FINISH && accel_en) begin
      done_d  = 1'b1;
      rdata_d = sat_relu(acc_q, relu_q);
    end
    if (hdr_acc) begin
      acc_d      = '0;
      relu_d     = bus_wdata[HDR_RELU_BIT];
      n_d        = hdr_clamp ? MAX_N_V : hdr_n;
      err_d      = hdr_clamp;
      pair_cnt_d = '0;
      phase_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q        <= '0;
      pair_cnt_q <= '0;
      phase_q    <= 1'b0;
      relu_q     <= 1'b0;
      prod_vld_q <= 1'b0;
      prod_q     <= '0;
      acc_q      <= '0;
      rdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      n_q        <= n_d;
      pair_cnt_q <= pair_cnt_d;
      phase_q    <= phase_d;
      relu_q     <= relu_d;
      prod_vld_q <= prod_vld_d;
      prod_q     <= prod_d;
      acc_q      <= acc_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign accel_done = done_q;
  assign bus_rdata  = rdata_q;
  assign err        = err_q;

endmodule

// File: tb/tb_neuron_mac_accel.sv
// Bench for neuron_mac_accel: table of jobs with expected results and done latency,
// plus hand-built abort, idle-write and mid-run reset sequences.
module tb_neuron_mac_accel;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        accel_en = 1'b0;
  logic        bus_wr = 1'b0;
  logic [15:0] bus_wdata = 16'h0000;
  logic        accel_done;
  logic [15:0] bus_rdata;
  logic        busy;
  logic        err;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [15:0] prev_rdata = 16'h0000;

  typedef struct {
    logic [15:0] rdata;
    int          at_cyc;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [15:0] hdr;
    logic [15:0] x;
    logic [15:0] w;
    int          np;
    bit          extra;
    logic [15:0] exp;
    bit          exp_err;
  } vec_t;
  vec_t tbl[9];

  neuron_mac_accel dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .accel_en   (accel_en),
    .bus_wr     (bus_wr),
    .bus_wdata  (bus_wdata),
    .accel_done (accel_done),
    .bus_rdata  (bus_rdata),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_done(input logic [15:0] rdata, input int at_cyc);
    sb_t e;
    e.rdata  = rdata;
    e.at_cyc = at_cyc;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (accel_done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_done", accel_done, 0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("rdata", bus_rdata, e.rdata);
        chk("done_latency", cyc, e.at_cyc);
      end
    end
  end

  task automatic run_job(input vec_t v, input int idx);
    @(negedge clk);
    accel_en = 1'b1;
    bus_wr   = 1'b0;
    @(negedge clk);
    bus_wr    = 1'b1;
    bus_wdata = v.hdr;
    if (v.np == 0) expect_done(v.exp, cyc + 2);
    @(negedge clk);
    chk($sformatf("row%0d_busy", idx), busy, 1);
    bus_wr = (v.np > 0);
    for (int i = 0; i < v.np; i++) begin
      bus_wdata = v.x;
      @(negedge clk);
      bus_wdata = v.w;
      if (i == v.np - 1) expect_done(v.exp, cyc + 5);
      @(negedge clk);
    end
    if (v.extra) begin
      bus_wdata = 16'h1234;
      @(negedge clk);
    end
    bus_wr = 1'b0;
    for (int t = 0; t < 40 && sb.size() > 0; t++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() > 0) begin
      chk($sformatf("row%0d_done_timeout", idx), sb.size(), 0);
      sb.delete();
    end
    chk($sformatf("row%0d_err", idx), err, v.exp_err);
    accel_en = 1'b0;
    @(negedge clk);
    chk($sformatf("row%0d_rdata_hold", idx), bus_rdata, v.exp);
    prev_rdata = v.exp;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time %0t exceeded", $time);
    $fatal(1);
  end

  initial begin
    vec_t fol;
    tbl[0] = '{16'h0001, 16'h0200, 16'h0180, 1,  1'b0, 16'h0300, 1'b0};
    tbl[1] = '{16'h0002, 16'h7FFF, 16'h7FFF, 2,  1'b0, 16'h7FFF, 1'b0};
    tbl[2] = '{16'h0002, 16'h7FFF, 16'h8000, 2,  1'b0, 16'h8000, 1'b0};
    tbl[3] = '{16'h8001, 16'h0100, 16'hFF00, 1,  1'b0, 16'h0000, 1'b0};
    tbl[4] = '{16'h0001, 16'h0100, 16'hFF00, 1,  1'b0, 16'hFF00, 1'b0};
    tbl[5] = '{16'h0001, 16'h0200, 16'h0180, 1,  1'b1, 16'h0300, 1'b1};
    tbl[6] = '{16'h0000, 16'h0000, 16'h0000, 0,  1'b0, 16'h0000, 1'b0};
    tbl[7] = '{16'h003F, 16'h0100, 16'h0100, 32, 1'b0, 16'h2000, 1'b1};
    tbl[8] = '{16'h0020, 16'h0100, 16'h0100, 32, 1'b0, 16'h2000, 1'b0};
    fol    = '{16'h0001, 16'h0100, 16'h0100, 1,  1'b0, 16'h0100, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_done", accel_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", bus_rdata, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // Writes while idle are ignored silently.
    bus_wr    = 1'b1;
    bus_wdata = 16'hFFFF;
    @(negedge clk);
    bus_wr = 1'b0;
    @(negedge clk);
    chk("idle_wr_err", err, 0);
    chk("idle_wr_busy", busy, 0);

    for (int r = 0; r < 5; r++) run_job(tbl[r], r);

    // Abort part-way through a 4-pair job.
    @(negedge clk);
    accel_en = 1'b1;
    @(negedge clk);
    bus_wr    = 1'b1;
    bus_wdata = 16'h0004;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus_wdata = 16'h0100;
    end
    @(negedge clk);
    accel_en = 1'b0;
    bus_wr   = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_rdata_hold", bus_rdata, prev_rdata);
    repeat (8) @(negedge clk);
    run_job(fol, 99);

    for (int r = 5; r < 9; r++) run_job(tbl[r], r);

    // Reset in the middle of a job.
    @(negedge clk);
    accel_en = 1'b1;
    @(negedge clk);
    bus_wr    = 1'b1;
    bus_wdata = 16'h0002;
    @(negedge clk);
    bus_wdata = 16'h0100;
    @(negedge clk);
    bus_wr   = 1'b0;
    accel_en = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", accel_done, 0);
    chk("midrst_err", err, 0);
    chk("midrst_rdata", bus_rdata, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("postrst_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
